// File: rtl/ftl_define.sv
// ---------------------------------------------------------------------------
// ftl_define
// Shared FTL constants: controller command geometry, opcodes, target codes,
// flash locations of the bad-block table and register save area, and the
// DRAM base of the bad-block table. Also holds the backup_dram state type.
// ---------------------------------------------------------------------------
package ftl_define;

    localparam int COMMAND_WIDTH      = 128;
    localparam int CHANNEL_ADDR_WIDTH = 3;
    localparam int DRAM_ADDR_WIDTH    = 29;
    // DRAM address bits above the 4 KB page offset
    localparam int DRAM_PAGE_WIDTH    = DRAM_ADDR_WIDTH - 12;
    localparam int NUM_CHANNELS       = 1 << CHANNEL_ADDR_WIDTH;

    localparam logic [23:0]                BADBLOCK_FLASH_ADDR1 = 24'h000000;
    localparam logic [23:0]                BADBLOCK_FLASH_ADDR2 = 24'h000018;
    localparam logic [DRAM_ADDR_WIDTH-1:0] BAD_BLOCK_INFO_BASE  = 29'h0100_0000;
    localparam logic [21:0]                REGISTER_BASE_FLASH  = 22'h000020;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ERASE = 2'b10
    } opcode_t;

    localparam logic [1:0] TARGET_TABLE    = 2'b10;
    localparam logic [1:0] TARGET_REGISTER = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_ERASE,
        S_ERASE_GAP,
        S_SEND_WRITE,
        S_WRITE_GAP,
        S_SEND_REGISTER,
        S_DONE
    } backup_state_t;

endpackage

// File: rtl/backup_dram_if.sv
// ---------------------------------------------------------------------------
// backup_dram_if
// Control/command bundle between backup_dram and its environment.
//   trigger_backup_dram            : start request (level)
//   all_Cmd_Available_flag         : every controller command FIFO has room
//   register_snapshot              : FTL register values to save
//   controller_command_fifo_in     : command word to the FIFOs
//   controller_command_fifo_in_en  : one-hot per-channel FIFO write enable
//   backup_busy / backup_done      : progress status
// slave  = backup_dram side, master = the driving side.
// ---------------------------------------------------------------------------
interface backup_dram_if;
    import ftl_define::*;

    logic                     trigger_backup_dram;
    logic                     all_Cmd_Available_flag;
    logic [63:0]              register_snapshot;
    logic [COMMAND_WIDTH-1:0] controller_command_fifo_in;
    logic [NUM_CHANNELS-1:0]  controller_command_fifo_in_en;
    logic                     backup_busy;
    logic                     backup_done;

    modport slave (
        input  trigger_backup_dram,
        input  all_Cmd_Available_flag,
        input  register_snapshot,
        output controller_command_fifo_in,
        output controller_command_fifo_in_en,
        output backup_busy,
        output backup_done
    );

    modport master (
        output trigger_backup_dram,
        output all_Cmd_Available_flag,
        output register_snapshot,
        input  controller_command_fifo_in,
        input  controller_command_fifo_in_en,
        input  backup_busy,
        input  backup_done
    );

endinterface

// File: rtl/ftl_cmd_pack.sv
// ---------------------------------------------------------------------------
// ftl_cmd_pack
// Combinational formatter for a 128-bit controller command (MSB first):
//   word3 = {op, 0, target, 27'b0}
//   word2 = {5'b0, channel, page_addr}
//   word1 = {12'b0, dram_page, channel}
//   word0 = {5'b0, page_addr, channel}
// Ports: op, target, channel, page_addr, dram_page (DRAM address >> 12) in;
//        command out.
// ---------------------------------------------------------------------------
module ftl_cmd_pack
    import ftl_define::*;
(
    input  opcode_t                       op,
    input  logic [1:0]                    target,
    input  logic [CHANNEL_ADDR_WIDTH-1:0] channel,
    input  logic [23:0]                   page_addr,
    input  logic [DRAM_PAGE_WIDTH-1:0]    dram_page,
    output logic [COMMAND_WIDTH-1:0]      command
);

    assign command = {op, 1'b0, target, 27'b0,
                      5'b0, channel, page_addr,
                      12'b0, dram_page, channel,
                      5'b0, page_addr, channel};

endmodule

// File: rtl/backup_dram.sv
// ---------------------------------------------------------------------------
// backup_dram
// Shutdown flush: erases the bad-block table block on every channel, writes
// each table page from DRAM back to flash on every channel, then saves the
// FTL register snapshot with one WRITE on channel 0.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-low
//   bus    : backup_dram_if.slave (trigger, FIFO-ready flag, snapshot,
//            command word + one-hot enable, busy/done status)
// Every command is followed by one gap cycle with the enable low.
// ---------------------------------------------------------------------------
module backup_dram
    import ftl_define::*;
(
    input  logic          clk,
    input  logic          reset,
    backup_dram_if.slave  bus
);

    backup_state_t                 state_q, state_nxt;
    logic [CHANNEL_ADDR_WIDTH-1:0] ch_q, ch_nxt;
    logic [23:0]                   page_q, page_nxt;
    logic [DRAM_ADDR_WIDTH-1:0]    dram_q, dram_nxt;
    logic [63:0]                   snap_q, snap_nxt;
    logic [COMMAND_WIDTH-1:0]      fifo_q, fifo_nxt;
    logic [NUM_CHANNELS-1:0]       en_q, en_nxt;
    logic                          busy_q, busy_nxt;
    logic                          done_q, done_nxt;

    opcode_t                       pk_op;
    logic [23:0]                   pk_page;
    logic [DRAM_PAGE_WIDTH-1:0]    pk_dram;
    logic [COMMAND_WIDTH-1:0]      table_cmd;
    logic [COMMAND_WIDTH-1:0]      register_cmd;

    // Erases always target the first table page and carry no DRAM address.
    always_comb begin
        pk_op   = OP_WRITE;
        pk_page = page_q;
        pk_dram = dram_q[DRAM_ADDR_WIDTH-1:12];
        if (state_q == S_SEND_ERASE) begin
            pk_op   = OP_ERASE;
            pk_page = BADBLOCK_FLASH_ADDR1;
            pk_dram = '0;
        end
    end

    ftl_cmd_pack u_cmd_pack (
        .op        (pk_op),
        .target    (TARGET_TABLE),
        .channel   (ch_q),
        .page_addr (pk_page),
        .dram_page (pk_dram),
        .command   (table_cmd)
    );

    // Register save uses its own layout: flash address in word2, raw snapshot
    // in the low 64 bits.
    assign register_cmd = {OP_WRITE, 1'b0, TARGET_REGISTER, 27'b0,
                           10'b0, REGISTER_BASE_FLASH, snap_q};

    always_comb begin
        state_nxt = state_q;
        ch_nxt    = ch_q;
        page_nxt  = page_q;
        dram_nxt  = dram_q;
        snap_nxt  = snap_q;
        fifo_nxt  = fifo_q;
        en_nxt    = '0;
        busy_nxt  = busy_q;
        done_nxt  = done_q;

        case (state_q)
            S_IDLE: begin
                if (bus.trigger_backup_dram) begin
                    snap_nxt  = bus.register_snapshot;
                    busy_nxt  = 1'b1;
                    state_nxt = S_SEND_ERASE;
                end
            end
            S_SEND_ERASE: begin
                if (bus.all_Cmd_Available_flag) begin
                    fifo_nxt  = table_cmd;
                    en_nxt    = NUM_CHANNELS'(1) << ch_q;
                    state_nxt = S_ERASE_GAP;
                end
            end
            S_ERASE_GAP: begin
                ch_nxt    = ch_q + 1'b1;
                state_nxt = (ch_nxt == '0) ? S_SEND_WRITE : S_SEND_ERASE;
            end
            S_SEND_WRITE: begin
                if (bus.all_Cmd_Available_flag) begin
                    fifo_nxt  = table_cmd;
                    en_nxt    = NUM_CHANNELS'(1) << ch_q;
                    state_nxt = S_WRITE_GAP;
                end
            end
            S_WRITE_GAP: begin
                ch_nxt    = ch_q + 1'b1;
                state_nxt = S_SEND_WRITE;
                // After the last channel of a page, move to the next table
                // page / DRAM 4 KB page, or finish with the register save.
                if (ch_nxt == '0) begin
                    if (page_q == BADBLOCK_FLASH_ADDR2) begin
                        state_nxt = S_SEND_REGISTER;
                    end else begin
                        page_nxt = page_q + 24'd8;
                        dram_nxt = dram_q + DRAM_ADDR_WIDTH'(4096);
                    end
                end
            end
            S_SEND_REGISTER: begin
                if (bus.all_Cmd_Available_flag) begin
                    fifo_nxt  = register_cmd;
                    en_nxt    = NUM_CHANNELS'(1);
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy_nxt = 1'b0;
                done_nxt = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            page_q  <= BADBLOCK_FLASH_ADDR1;
            dram_q  <= BAD_BLOCK_INFO_BASE;
            snap_q  <= '0;
            fifo_q  <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ch_q    <= ch_nxt;
            page_q  <= page_nxt;
            dram_q  <= dram_nxt;
            snap_q  <= snap_nxt;
            fifo_q  <= fifo_nxt;
            en_q    <= en_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    assign bus.controller_command_fifo_in    = fifo_q;
    assign bus.controller_command_fifo_in_en = en_q;
    assign bus.backup_busy                   = busy_q;
    assign bus.backup_done                   = done_q;

endmodule

// File: tb/tb_backup_dram.sv
// ---------------------------------------------------------------------------
// tb_backup_dram
// Directed bench for backup_dram: reset state, full 41-command sequence,
// page stepping, snapshot capture, retrigger after DONE, reset mid-run,
// and a randomly toggling FIFO-ready flag.
// ---------------------------------------------------------------------------
module tb_backup_dram;
    import ftl_define::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    backup_dram_if bus();

    backup_dram dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    // Pulse recorder
    logic [127:0] mon_cmd  [0:511];
    logic [7:0]   mon_en   [0:511];
    int           mon_cyc  [0:511];
    logic         mon_done [0:511];
    int           mon_cnt   = 0;
    int           flag_viol = 0;
    logic         last_flag = 1'b0;

    always @(negedge clk) begin
        if (bus.controller_command_fifo_in_en != 8'h00) begin
            if (mon_cnt < 512) begin
                mon_cmd[mon_cnt]  = bus.controller_command_fifo_in;
                mon_en[mon_cnt]   = bus.controller_command_fifo_in_en;
                mon_cyc[mon_cnt]  = cyc;
                mon_done[mon_cnt] = bus.backup_done;
            end
            mon_cnt++;
            if (!last_flag) flag_viol++;
        end
        last_flag = bus.all_Cmd_Available_flag;
    end

    // Expected command for the i-th pulse (0-based) of a backup run
    function automatic logic [127:0] exp_cmd(input int i, input logic [63:0] s);
        logic [2:0]  ch;
        logic [23:0] pg;
        logic [16:0] dp;
        int          j;
        if (i < 8) begin
            ch = 3'(i);
            pg = 24'h0;
            dp = 17'h0;
            return {2'b10, 1'b0, 2'b10, 27'b0, 5'b0, ch, pg,
                    12'b0, dp, ch, 5'b0, pg, ch};
        end else if (i < 40) begin
            j  = i - 8;
            ch = 3'(j % 8);
            pg = 24'(8 * (j / 8));
            dp = 17'h1000 + 17'(j / 8);
            return {2'b01, 1'b0, 2'b10, 27'b0, 5'b0, ch, pg,
                    12'b0, dp, ch, 5'b0, pg, ch};
        end
        return {32'h4800_0000, 32'h0000_0020, s};
    endfunction

    function automatic logic [7:0] exp_en(input int i);
        if (i < 40) return 8'(1 << (i % 8));
        return 8'h01;
    endfunction

    task automatic do_trigger(output int c0);
        @(posedge clk);
        #1 bus.trigger_backup_dram = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        bus.trigger_backup_dram = 1'b0;
    endtask

    task automatic wait_pulses(input int base, input int n, input int budget,
                               output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (mon_cnt - base >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.trigger_backup_dram    = 1'b0;
        bus.all_Cmd_Available_flag = 1'b1;
        bus.register_snapshot      = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.controller_command_fifo_in_en !== 8'h00) begin
            errors++; $display("FAIL reset_en got=%h want=00", bus.controller_command_fifo_in_en);
        end
        checks++;
        if (bus.controller_command_fifo_in !== 128'h0) begin
            errors++; $display("FAIL reset_fifo got=%h want=0", bus.controller_command_fifo_in);
        end
        checks++;
        if (bus.backup_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b want=0", bus.backup_busy);
        end
        checks++;
        if (bus.backup_done !== 1'b0) begin
            errors++; $display("FAIL reset_done got=%b want=0", bus.backup_done);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        begin
            int base;
            base = mon_cnt;
            repeat (10) @(posedge clk);
            checks++;
            if (mon_cnt != base) begin
                errors++; $display("FAIL idle_no_pulse got=%0d want=0", mon_cnt - base);
            end
        end
    endtask

    task automatic test_full_sequence;
        int          base, c0;
        bit          ok;
        logic [127:0] c;
        logic [63:0] snap;
        snap = 64'hDEAD_BEEF_0123_4567;
        bus.all_Cmd_Available_flag = 1'b1;
        bus.register_snapshot      = snap;
        base = mon_cnt;
        do_trigger(c0);
        bus.register_snapshot = 64'h1111_2222_3333_4444;
        @(negedge clk);
        checks++;
        if (bus.backup_busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_trigger got=%b want=1", bus.backup_busy);
        end
        wait_pulses(base, 41, 200, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL full_timeout got=%0d pulses want=41", mon_cnt - base);
        end
        repeat (6) @(posedge clk);
        checks++;
        if (mon_cnt - base != 41) begin
            errors++; $display("FAIL full_count got=%0d want=41", mon_cnt - base);
        end
        for (int k = 0; k < 41; k++) begin
            checks++;
            if (mon_en[base+k] !== exp_en(k)) begin
                errors++; $display("FAIL full_en[%0d] got=%h want=%h", k, mon_en[base+k], exp_en(k));
            end
            checks++;
            if (mon_cmd[base+k] !== exp_cmd(k, snap)) begin
                errors++; $display("FAIL full_cmd[%0d] got=%h want=%h", k, mon_cmd[base+k], exp_cmd(k, snap));
            end
            checks++;
            if (mon_cyc[base+k] != c0 + 1 + 2 * k) begin
                errors++; $display("FAIL full_cycle[%0d] got=%0d want=%0d", k, mon_cyc[base+k] - c0, 1 + 2 * k);
            end
        end
        // Pulse 9: first table write
        c = mon_cmd[base+8];
        checks++;
        if (c[127:126] !== 2'b01 || c[26:3] !== 24'h0 || c[51:35] !== 17'h1000) begin
            errors++; $display("FAIL pulse9_fields got op=%b page=%h dram=%h want op=01 page=000000 dram=1000", c[127:126], c[26:3], c[51:35]);
        end
        // Pulse 17: second table page
        c = mon_cmd[base+16];
        checks++;
        if (c[26:3] !== 24'h8 || c[51:35] !== 17'h1001 || c[2:0] !== 3'd0) begin
            errors++; $display("FAIL pulse17_fields got page=%h dram=%h ch=%0d want page=000008 dram=1001 ch=0", c[26:3], c[51:35], c[2:0]);
        end
        // Pulse 40: last table page, channel 7
        c = mon_cmd[base+39];
        checks++;
        if (c[26:3] !== 24'h18 || mon_en[base+39] !== 8'h80) begin
            errors++; $display("FAIL pulse40_fields got page=%h en=%h want page=000018 en=80", c[26:3], mon_en[base+39]);
        end
        // Pulse 41: register save with captured snapshot
        c = mon_cmd[base+40];
        checks++;
        if (c[127:96] !== 32'h4800_0000 || c[63:0] !== 64'hDEAD_BEEF_0123_4567) begin
            errors++; $display("FAIL pulse41_reg got w3=%h snap=%h want w3=48000000 snap=deadbeef01234567", c[127:96], c[63:0]);
        end
        checks++;
        if (mon_done[base+40] !== 1'b0) begin
            errors++; $display("FAIL done_early got=%b want=0", mon_done[base+40]);
        end
        @(negedge clk);
        checks++;
        if (bus.backup_done !== 1'b1) begin
            errors++; $display("FAIL done_after got=%b want=1", bus.backup_done);
        end
        checks++;
        if (bus.backup_busy !== 1'b0) begin
            errors++; $display("FAIL busy_after_done got=%b want=0", bus.backup_busy);
        end
    endtask

    task automatic test_done_retrigger;
        int base, c0;
        base = mon_cnt;
        do_trigger(c0);
        repeat (30) @(posedge clk);
        checks++;
        if (mon_cnt != base) begin
            errors++; $display("FAIL retrigger_pulses got=%0d want=0 (c0=%0d)", mon_cnt - base, c0);
        end
        @(negedge clk);
        checks++;
        if (bus.backup_done !== 1'b1) begin
            errors++; $display("FAIL retrigger_done got=%b want=1", bus.backup_done);
        end
    endtask

    task automatic test_reset_mid;
        int          base, c0;
        bit          ok;
        logic [63:0] snap;
        snap = 64'h0123_4567_89AB_CDEF;
        bus.all_Cmd_Available_flag = 1'b1;
        bus.register_snapshot      = snap;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        base = mon_cnt;
        do_trigger(c0);
        wait_pulses(base, 20, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL mid_timeout got=%0d pulses want=20", mon_cnt - base);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus.controller_command_fifo_in_en !== 8'h00 || bus.controller_command_fifo_in !== 128'h0) begin
            errors++; $display("FAIL mid_reset_cmd got en=%h fifo=%h want 0", bus.controller_command_fifo_in_en, bus.controller_command_fifo_in);
        end
        checks++;
        if (bus.backup_busy !== 1'b0 || bus.backup_done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_status got busy=%b done=%b want 0 0", bus.backup_busy, bus.backup_done);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        base = mon_cnt;
        do_trigger(c0);
        wait_pulses(base, 41, 200, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL restart_timeout got=%0d pulses want=41", mon_cnt - base);
        end
        repeat (6) @(posedge clk);
        checks++;
        if (mon_cnt - base != 41) begin
            errors++; $display("FAIL restart_count got=%0d want=41", mon_cnt - base);
        end
        checks++;
        if (mon_cmd[base][127:126] !== 2'b10 || mon_en[base] !== 8'h01) begin
            errors++; $display("FAIL restart_first got op=%b en=%h want op=10 en=01", mon_cmd[base][127:126], mon_en[base]);
        end
        for (int k = 0; k < 41; k++) begin
            checks++;
            if (mon_en[base+k] !== exp_en(k) || mon_cmd[base+k] !== exp_cmd(k, snap)) begin
                errors++; $display("FAIL restart_cmd[%0d] got en=%h cmd=%h want en=%h cmd=%h", k, mon_en[base+k], mon_cmd[base+k], exp_en(k), exp_cmd(k, snap));
            end
        end
    endtask

    task automatic test_flag_toggle;
        int          base, c0, viol0;
        bit          ok;
        logic [63:0] snap;
        snap = 64'hCAFE_F00D_5A5A_A5A5;
        bus.all_Cmd_Available_flag = 1'b1;
        bus.register_snapshot      = snap;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        viol0 = flag_viol;
        base  = mon_cnt;
        do_trigger(c0);
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            if (mon_cnt - base >= 41) begin
                ok = 1'b1;
                break;
            end
            #1 bus.all_Cmd_Available_flag = 1'($urandom_range(0, 1));
        end
        #1 bus.all_Cmd_Available_flag = 1'b1;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL toggle_timeout got=%0d pulses want=41", mon_cnt - base);
        end
        repeat (6) @(posedge clk);
        checks++;
        if (mon_cnt - base != 41) begin
            errors++; $display("FAIL toggle_count got=%0d want=41", mon_cnt - base);
        end
        checks++;
        if (flag_viol != viol0) begin
            errors++; $display("FAIL toggle_flag_low_issue got=%0d want=0", flag_viol - viol0);
        end
        for (int k = 0; k < 41; k++) begin
            checks++;
            if (mon_en[base+k] !== exp_en(k) || mon_cmd[base+k] !== exp_cmd(k, snap)) begin
                errors++; $display("FAIL toggle_cmd[%0d] got en=%h cmd=%h want en=%h cmd=%h", k, mon_en[base+k], mon_cmd[base+k], exp_en(k), exp_cmd(k, snap));
            end
        end
        @(negedge clk);
        checks++;
        if (bus.backup_done !== 1'b1) begin
            errors++; $display("FAIL toggle_done got=%b want=1", bus.backup_done);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.trigger_backup_dram    = 1'b0;
        bus.all_Cmd_Available_flag = 1'b0;
        bus.register_snapshot      = 64'h0;
        test_reset();
        test_full_sequence();
        test_done_retrigger();
        test_reset_mid();
        test_flag_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
